// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types for the unified-memory arbiter: FSM state encoding, the
//   owner tag that records which requester holds the current transaction,
//   and the fixed-priority-with-starvation-guard winner selection.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    // Data wins by default; fetch wins only when it has been passed over
    // the maximum number of times in a row. With no request at all the
    // result is meaningless and must be qualified by the caller.
    function automatic owner_t pick_owner(input logic i_req,
                                          input logic d_req,
                                          input logic starved);
        if (d_req && !(i_req && starved)) begin
            return OWNER_D;
        end
        return OWNER_I;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
//   Clearable saturating cycle counter with a hit flag.
//   hit is high during the LIMIT-th enabled cycle after a clear (and stays
//   high while saturated), so a consumer acting on hit aborts after exactly
//   LIMIT counted cycles.
// Ports
//   clk  in  clock, rising edge
//   rst  in  asynchronous reset, active-low
//   clr  in  synchronous clear (takes priority over en)
//   en   in  count this cycle
//   hit  out counter has reached LIMIT counted cycles (including this one)
// -----------------------------------------------------------------------------
module mem_arb_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of enabled cycles already completed, so cnt==LIMIT-1
    // means the current cycle is the LIMIT-th one.
    assign hit = (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between instruction fetch (I) and the
//   load/store path (D). One transaction outstanding at a time:
//   IDLE (arbitrate, pulse gnt) -> ISSUE (mem_req held until mem_ready)
//   -> WAIT_RESP (until mem_rvalid or timeout) -> IDLE.
//   Data has priority; fetch is forced through after MAX_STARVE consecutive
//   data grants while it waits. A response timeout completes the owner's
//   transaction with zero data and sets the sticky err flag.
// Ports
//   clk, rst                       clock / async active-low reset
//   i_req, i_addr                  fetch request (held until i_gnt)
//   i_gnt, i_rvalid, i_rdata       fetch grant pulse, response pulse, data
//   d_req, d_we, d_addr, d_wdata   load/store request (held until d_gnt)
//   d_gnt, d_rvalid, d_rdata       data grant pulse, response pulse, load data
//   mem_req/we/addr/wdata          memory request side, valid while mem_req
//   mem_ready, mem_rvalid, mem_rdata  memory accept, response pulse, read data
//   err                            sticky: timeout or spurious mem_rvalid
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int STARVE_W = $clog2(MAX_STARVE + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_STARVE);

    state_t              state;
    state_t              state_nxt;
    owner_t              owner;
    owner_t              winner;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic                grant_i;
    logic                grant_d;
    logic                complete;
    logic                abort;
    logic                timer_hit;
    logic                in_wait;
    logic                issuing;

    assign in_wait = (state == WAIT_RESP);
    assign issuing = (state == ISSUE);

    mem_arb_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (!in_wait),
        .en  (in_wait),
        .hit (timer_hit)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, arbitration and starvation bookkeeping
    always_comb begin
        state_nxt  = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        starve_nxt = starve_cnt;
        complete   = 1'b0;
        abort      = 1'b0;
        winner     = pick_owner(i_req, d_req, starve_cnt == STARVE_LIM);

        case (state)
            IDLE: begin
                grant_d = d_req && (winner == OWNER_D);
                grant_i = i_req && (winner == OWNER_I);
                // Any IDLE cycle without a fetch waiting breaks the run of
                // consecutive data wins, as does a fetch grant itself.
                if (grant_i || !i_req) begin
                    starve_nxt = '0;
                end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
                    starve_nxt = starve_cnt + 1'b1;
                end
                if (grant_i || grant_d) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving in the timeout cycle still counts.
                if (mem_rvalid) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (timer_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, starvation counter, response and error registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWNER_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;

            if (grant_d) begin
                owner   <= OWNER_D;
                we_q    <= d_we;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end else if (grant_i) begin
                owner   <= OWNER_I;
                we_q    <= 1'b0;
                addr_q  <= i_addr;
                wdata_q <= '0;
            end

            // Response outputs are zero except in the single completion cycle.
            i_rvalid <= (complete || abort) && (owner == OWNER_I);
            d_rvalid <= (complete || abort) && (owner == OWNER_D);
            i_rdata  <= (complete && (owner == OWNER_I)) ? mem_rdata : '0;
            d_rdata  <= (complete && (owner == OWNER_D) && !we_q) ? mem_rdata : '0;

            if (abort || (mem_rvalid && !in_wait)) begin
                err <= 1'b1;
            end
        end
    end

    // Grants are combinational from IDLE; hold them low while reset is asserted.
    assign i_gnt = grant_i & rst;
    assign d_gnt = grant_d & rst;

    // The memory side shows the latched request only while it is being issued.
    assign mem_req   = issuing;
    assign mem_we    = issuing & we_q;
    assign mem_addr  = issuing ? addr_q  : '0;
    assign mem_wdata = issuing ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAX_STARVE = 4;
    localparam int TIMEOUT    = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state: memory contents, consecutive-D-win count,
    // expected response of the last transaction, expected sticky error.
    logic [31:0] marr [16];
    int          starve = 0;
    bit          pend_i = 0;
    bit          pend_d = 0;
    logic [31:0] pend_data = '0;
    bit          exp_err = 0;
    bit          last_win_d = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_gnt"},     32'(i_gnt),    32'(0));
        check({tag, "_d_gnt"},     32'(d_gnt),    32'(0));
        check({tag, "_i_rvalid"},  32'(i_rvalid), 32'(0));
        check({tag, "_d_rvalid"},  32'(d_rvalid), 32'(0));
        check({tag, "_i_rdata"},   i_rdata,       32'(0));
        check({tag, "_d_rdata"},   d_rdata,       32'(0));
        check({tag, "_mem_req"},   32'(mem_req),  32'(0));
        check({tag, "_mem_we"},    32'(mem_we),   32'(0));
        check({tag, "_mem_addr"},  mem_addr,      32'(0));
        check({tag, "_mem_wdata"}, mem_wdata,     32'(0));
        check({tag, "_err"},       32'(err),      32'(0));
    endtask

    // Compares the response pulse owed by the previous transaction (or none).
    task automatic check_pending();
        check("i_rvalid", 32'(i_rvalid), 32'(pend_i));
        check("d_rvalid", 32'(d_rvalid), 32'(pend_d));
        check("i_rdata",  i_rdata, pend_i ? pend_data : 32'(0));
        check("d_rdata",  d_rdata, pend_d ? pend_data : 32'(0));
        check("err",      32'(err), 32'(exp_err));
        pend_i = 0;
        pend_d = 0;
    endtask

    // One cycle with no new request; called just after a rising edge.
    task automatic idle_cycle();
        if (!i_req) starve = 0;
        @(negedge clk);
        check_pending();
        check("idle_i_gnt",   32'(i_gnt),   32'(0));
        check("idle_d_gnt",   32'(d_gnt),   32'(0));
        check("idle_mem_req", 32'(mem_req), 32'(0));
        @(posedge clk); #1;
    endtask

    // One complete transaction. Called just after a rising edge with the
    // arbiter idle and the request lines already set for this cycle.
    // drop_mode: 0 = winner withdraws, 1 = both keep requesting, 2 = both withdraw.
    task automatic one_txn(input int rdy_dly, input int rsp_dly, input bit no_rsp, input int drop_mode);
        bit          win_d;
        bit          e_we;
        logic [31:0] e_addr, e_wdata, rd;
        int          idx;

        win_d = d_req && !(i_req && starve == MAX_STARVE);
        if (win_d && i_req) starve = (starve < MAX_STARVE) ? starve + 1 : starve;
        else                starve = 0;
        e_we    = win_d ? d_we : 1'b0;
        e_addr  = win_d ? d_addr : i_addr;
        e_wdata = win_d ? d_wdata : 32'(0);
        last_win_d = win_d;

        @(negedge clk);
        check_pending();
        check("i_gnt",        32'(i_gnt),   32'(!win_d));
        check("d_gnt",        32'(d_gnt),   32'(win_d));
        check("mem_req_idle", 32'(mem_req), 32'(0));
        @(posedge clk); #1;

        // Withdrawn requesters scramble their fields to prove the latch holds.
        case (drop_mode)
            0: begin
                if (win_d) begin d_req = 0; d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
                else       begin i_req = 0; i_addr = $urandom; end
            end
            2: begin i_req = 0; d_req = 0; end
            default: ;
        endcase

        for (int j = 0; j <= rdy_dly; j++) begin
            mem_ready = (j == rdy_dly);
            @(negedge clk);
            check("mem_req",   32'(mem_req), 32'(1));
            check("mem_we",    32'(mem_we),  32'(e_we));
            check("mem_addr",  mem_addr,     e_addr);
            check("mem_wdata", mem_wdata,    e_wdata);
            check("issue_gnt", 32'(i_gnt | d_gnt), 32'(0));
            @(posedge clk); #1;
        end
        mem_ready = 0;

        idx = int'(e_addr[5:2]);
        rd  = marr[idx];
        if (no_rsp) begin
            for (int j = 0; j < TIMEOUT; j++) begin
                @(negedge clk);
                check("to_wait_rvalid",  32'(i_rvalid | d_rvalid), 32'(0));
                check("to_wait_mem_req", 32'(mem_req), 32'(0));
                @(posedge clk); #1;
            end
            pend_data = 32'(0);
            exp_err   = 1;
        end else begin
            for (int j = 0; j <= rsp_dly; j++) begin
                mem_rvalid = (j == rsp_dly);
                mem_rdata  = (j == rsp_dly && !e_we) ? rd : $urandom;
                @(negedge clk);
                check("wait_rvalid",  32'(i_rvalid | d_rvalid), 32'(0));
                check("wait_mem_req", 32'(mem_req), 32'(0));
                check("wait_gnt",     32'(i_gnt | d_gnt), 32'(0));
                @(posedge clk); #1;
            end
            mem_rvalid = 0;
            mem_rdata  = $urandom;
            pend_data  = e_we ? 32'(0) : rd;
            if (e_we) marr[idx] = e_wdata;
        end
        pend_i = !win_d;
        pend_d = win_d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] order;
        for (int k = 0; k < 16; k++) marr[k] = $urandom;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;

        // Lone fetch of 0x40 returning 0x00500093
        marr[0] = 32'h0050_0093;
        i_req = 1; i_addr = 32'h40;
        one_txn(0, 0, 0, 0);
        idle_cycle();

        // Both requesters held: D,D,D,D,I,D,D,D,D,I
        order = '0;
        i_req = 1; i_addr = 32'h8;
        d_req = 1; d_we = 0; d_addr = 32'h10; d_wdata = 32'h0;
        for (int n = 0; n < 10; n++) begin
            one_txn(0, 0, 0, (n == 9) ? 2 : 1);
            order = {order[8:0], last_win_d};
        end
        idle_cycle();
        check("grant_order", 32'(order), 32'(10'b1111011110));

        // Store with memory stalling five cycles
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        one_txn(5, 0, 0, 0);
        idle_cycle();

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1; i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom;
            end
            if (!i_req && !d_req) begin
                i_req = 1; i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            one_txn($urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
        end
        for (int n = 0; n < 2; n++) begin
            if (i_req || d_req) one_txn(0, 0, 0, 0);
        end
        idle_cycle();

        // Response timeout, then a late spurious response
        d_req = 1; d_we = 0; d_addr = 32'h24;
        one_txn(0, 0, 1, 0);
        idle_cycle();
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid = 0;
        idle_cycle();

        // Asynchronous reset while waiting for a response
        d_req = 1; d_we = 0; d_addr = 32'h20;
        @(negedge clk);
        check("rst_txn_d_gnt", 32'(d_gnt), 32'(1));
        @(posedge clk); #1;
        d_req = 0; mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        #2 rst = 0;
        #1 check_all_zero("async_rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all_zero("rst_held");
        rst = 1;
        starve = 0; exp_err = 0; pend_i = 0; pend_d = 0;
        i_req = 1; i_addr = 32'h44;
        one_txn(0, 1, 0, 0);
        idle_cycle();

        // mem_rvalid with nothing outstanding
        mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rvalid = 0;
        exp_err = 1;
        idle_cycle();
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
